// File: rtl/fpu_normalize_pack_if.sv
// Operand/result handshake bundle for fpu_normalize_pack.
// Compile with +define+FPU_NORM_FLAGS_EN to add the exception flag signals.
interface fpu_normalize_pack_if #(
    parameter int bitness = 64
);
    localparam int EW = (bitness == 16)  ? 5  :
                        (bitness == 32)  ? 8  :
                        (bitness == 64)  ? 11 :
                        (bitness == 128) ? 15 : 19;
    localparam int MW = bitness - EW;

    // Both channels: a transfer occurs on a rising clk edge where valid && ready
    // are both high; the sender keeps valid and its payload stable until then.
    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic [EW+1:0]      in_exp;
    logic [MW+3:0]      in_mant;
    logic               out_valid;
    logic               out_ready;
    logic [bitness-1:0] result;
`ifdef FPU_NORM_FLAGS_EN
    logic               flag_overflow;
    logic               flag_underflow;
    logic               flag_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, result,
               flag_overflow, flag_underflow, flag_inexact
    );
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, result,
               flag_overflow, flag_underflow, flag_inexact
    );
`else
    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, result
    );
`endif
endinterface

// File: rtl/fpu_normalize_pack.sv
// Iterative normalize, round-to-nearest-even and IEEE-754 pack stage.
// Optional exception flags are generated when FPU_NORM_FLAGS_EN is defined.
module fpu_normalize_pack #(
    parameter int bitness = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_normalize_pack_if.slave  bus,
    output logic [1:0]           state_dbg
);
    localparam int EW = (bitness == 16)  ? 5  :
                        (bitness == 32)  ? 8  :
                        (bitness == 64)  ? 11 :
                        (bitness == 128) ? 15 : 19;
    localparam int MW = bitness - EW;

    localparam logic signed [EW+1:0] EXP_ONE  = (EW+2)'(1);
    localparam logic signed [EW+2:0] EXPW_ONE = (EW+3)'(1);
    localparam logic signed [EW+2:0] EXP_INF  = (EW+3)'((1 << EW) - 1);

    typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

    state_t                 state;
    logic                   sign_q;
    logic signed [EW+1:0]   exp_q;
    logic [MW+3:0]          mant_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [bitness-1:0]     result_q;

    logic [MW-1:0]          sig;
    logic                   round_up;
    logic [MW:0]            sum;
    logic [MW-1:0]          sig_r;
    logic signed [EW+2:0]   exp_w;
    logic signed [EW+2:0]   exp_r;
    logic                   is_inf;
    logic [bitness-1:0]     packed_word;
`ifdef FPU_NORM_FLAGS_EN
    logic                   inexact;
    logic                   flag_ovf_q;
    logic                   flag_unf_q;
    logic                   flag_inx_q;
`endif

    // Rounding is evaluated on the already-aligned registers and consumed in ROUND.
    always_comb begin
        sig      = mant_q[MW+2:3];
        round_up = mant_q[2] & (mant_q[1] | mant_q[0] | sig[0]);
        sum      = {1'b0, sig} + {{MW{1'b0}}, round_up};
        exp_w    = {exp_q[EW+1], exp_q};
        if (sum[MW]) begin
            sig_r = sum[MW:1];
            exp_r = exp_w + EXPW_ONE;
        end else begin
            sig_r = sum[MW-1:0];
            exp_r = exp_w;
        end
        is_inf = (exp_r >= EXP_INF);
        if (is_inf)
            packed_word = {sign_q, {EW{1'b1}}, {(MW-1){1'b0}}};
        else if (!sig_r[MW-1])
            packed_word = {sign_q, {EW{1'b0}}, sig_r[MW-2:0]};
        else
            packed_word = {sign_q, exp_r[EW-1:0], sig_r[MW-2:0]};
`ifdef FPU_NORM_FLAGS_EN
        inexact = mant_q[2] | mant_q[1] | mant_q[0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
`ifdef FPU_NORM_FLAGS_EN
            flag_ovf_q  <= 1'b0;
            flag_unf_q  <= 1'b0;
            flag_inx_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        sign_q     <= bus.in_sign;
                        exp_q      <= bus.in_exp;
                        mant_q     <= bus.in_mant;
                        in_ready_q <= 1'b0;
                        state      <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (mant_q == '0) begin
                        result_q    <= {sign_q, {(bitness-1){1'b0}}};
                        out_valid_q <= 1'b1;
                        state       <= DONE;
`ifdef FPU_NORM_FLAGS_EN
                        flag_ovf_q  <= 1'b0;
                        flag_unf_q  <= 1'b0;
                        flag_inx_q  <= 1'b0;
`endif
                    end else if (mant_q[MW+3] || (exp_q < EXP_ONE)) begin
                        // Right shift keeps every discarded bit alive in sticky.
                        mant_q <= {1'b0, mant_q[MW+3:2], mant_q[1] | mant_q[0]};
                        exp_q  <= exp_q + EXP_ONE;
                    end else if (!mant_q[MW+2] && (exp_q > EXP_ONE)) begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - EXP_ONE;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    result_q    <= packed_word;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
`ifdef FPU_NORM_FLAGS_EN
                    flag_ovf_q  <= is_inf;
                    flag_unf_q  <= !is_inf && !sig_r[MW-1] && inexact;
                    flag_inx_q  <= inexact;
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
`ifdef FPU_NORM_FLAGS_EN
                        flag_ovf_q  <= 1'b0;
                        flag_unf_q  <= 1'b0;
                        flag_inx_q  <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign state_dbg     = state;
`ifdef FPU_NORM_FLAGS_EN
    assign bus.flag_overflow  = flag_ovf_q;
    assign bus.flag_underflow = flag_unf_q;
    assign bus.flag_inexact   = flag_inx_q;
`endif
endmodule

// File: tb/tb_fpu_normalize_pack.sv
// Bench for fpu_normalize_pack at bitness=32: exact-value rounding model, directed and random operands.
// Flag checks are active when FPU_NORM_FLAGS_EN is defined.
module tb_fpu_normalize_pack;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       hold_ready = 1'b0;
    logic       bp_rand = 1'b0;
    logic       seen_head = 1'b0;

    // expected entry: {overflow, underflow, inexact, result[31:0]}
    logic [34:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];

    fpu_normalize_pack_if #(.bitness(32)) bus();

    fpu_normalize_pack #(.bitness(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Operand value is exactly mant * 2^(exp - 127 - 26); round that to binary32 RNE.
    function automatic logic [34:0] model(input logic s, input int e, input logic [27:0] m);
        longint mant, kept, rem, half;
        int     p, big_e, q, sh, ebits;
        logic   inx;
        logic   [31:0] res;
        logic   ovf;
        mant = longint'(m);
        ovf  = 1'b0;
        if (m == 28'd0) return {3'b000, s, 31'd0};
        p = 27;
        while (m[p] == 1'b0) p--;
        big_e = e - 153 + p;
        q = (big_e >= -126) ? big_e - 23 : -149;
        sh = q - (e - 153);
        if (sh > 40) begin
            kept = 0;
            inx  = 1'b1;
        end else if (sh > 0) begin
            kept = mant >> sh;
            rem  = mant & ((64'sd1 <<< sh) - 1);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
            inx = (rem != 0);
        end else begin
            kept = mant <<< (-sh);
            inx  = 1'b0;
        end
        if (kept == 0) begin
            res = {s, 31'd0};
        end else begin
            if (kept >= (64'sd1 <<< 24)) begin
                kept = kept >> 1;
                q    = q + 1;
            end
            if (kept >= (64'sd1 <<< 23)) begin
                ebits = q + 23 + 127;
                if (ebits >= 255) begin
                    res = {s, 8'hFF, 23'd0};
                    ovf = 1'b1;
                end else begin
                    res = {s, ebits[7:0], kept[22:0]};
                end
            end else begin
                res = {s, 8'd0, kept[22:0]};
            end
        end
        return {ovf, inx && (res[30:23] == 8'd0), inx, res};
    endfunction

    task automatic check_model(input string name, input logic [34:0] got, input logic [34:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: model gives %h, hand value %h", name, got, want);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_op(input logic s, input int e, input logic [27:0] m, input int lat);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = 10'(e);
        bus.in_mant  = m;
        @(negedge clk);
        while (!bus.in_ready && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, state=%0d", bus.in_ready, guard, state_dbg);
        end else begin
            exp_q.push_back(model(s, e, m));
            lat_q.push_back(lat);
            acc_q.push_back(cyc);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, state=%0d", exp_q.size(), state_dbg);
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (hold_ready)   bus.out_ready = 1'b0;
            else if (bp_rand) bus.out_ready = 1'($urandom_range(0, 1));
            else              bus.out_ready = 1'b1;
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_head = 1'b0;
        end else if (bus.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: result=%h with nothing outstanding", bus.result);
            end else begin
                if (bus.result !== exp_q[0][31:0]) begin
                    errors++;
                    $display("FAIL result: got %h, expected %h", bus.result, exp_q[0][31:0]);
                end
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_busy: got %b, expected 0", bus.in_ready);
                end
`ifdef FPU_NORM_FLAGS_EN
                checks++;
                if ({bus.flag_overflow, bus.flag_underflow, bus.flag_inexact} !== exp_q[0][34:32]) begin
                    errors++;
                    $display("FAIL flags: got ovf/unf/inx=%b%b%b, expected %b", bus.flag_overflow,
                             bus.flag_underflow, bus.flag_inexact, exp_q[0][34:32]);
                end
`endif
                if (!seen_head) begin
                    seen_head = 1'b1;
                    if (lat_q[0] >= 0) begin
                        checks++;
                        if (cyc - acc_q[0] != lat_q[0]) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, expected %0d", cyc - acc_q[0], lat_q[0]);
                        end
                    end
                end
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    void'(lat_q.pop_front());
                    void'(acc_q.pop_front());
                    seen_head = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, state=%0d", state_dbg);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic        s;
        int          e;
        logic [27:0] m;
        int          guard;

        bus.in_valid = 1'b0;
        bus.in_sign  = 1'b0;
        bus.in_exp   = '0;
        bus.in_mant  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h, expected 1 0 00000000",
                     bus.in_ready, bus.out_valid, bus.result);
        end
`ifdef FPU_NORM_FLAGS_EN
        checks++;
        if ({bus.flag_overflow, bus.flag_underflow, bus.flag_inexact} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b%b%b, expected 000", bus.flag_overflow,
                     bus.flag_underflow, bus.flag_inexact);
        end
`endif
        rst_n = 1'b1;

        check_model("pin_one",     model(1'b0, 127, 28'h4000000), {3'b000, 32'h3F800000});
        check_model("pin_left",    model(1'b0, 130, 28'h0800000), {3'b000, 32'h3F800000});
        check_model("pin_carry",   model(1'b0, 127, 28'h8000000), {3'b000, 32'h40000000});
        check_model("pin_tie_dn",  model(1'b0, 127, 28'h4000004), {3'b001, 32'h3F800000});
        check_model("pin_tie_up",  model(1'b0, 127, 28'h400000C), {3'b001, 32'h3F800002});
        check_model("pin_inf",     model(1'b1, 255, 28'h4000000), {3'b100, 32'hFF800000});
        check_model("pin_zero",    model(1'b1, 100, 28'h0000000), {3'b000, 32'h80000000});
        check_model("pin_subnorm", model(1'b0, -22, 28'h4000000), {3'b000, 32'h00000001});

        send_op(1'b0, 127, 28'h4000000, 3); wait_done();
        send_op(1'b0, 130, 28'h0800000, 6); wait_done();
        send_op(1'b0, 127, 28'h8000000, 4); wait_done();
        send_op(1'b0, 127, 28'h4000004, 3); wait_done();
        send_op(1'b0, 127, 28'h400000C, 3); wait_done();
        send_op(1'b1, 255, 28'h4000000, 3); wait_done();
        send_op(1'b1, 100, 28'h0000000, 2); wait_done();
        send_op(1'b0, -22, 28'h4000000, -1); wait_done();
        send_op(1'b0, 254, 28'hFFFFFFF, -1); wait_done();

        // backpressure: result must sit unchanged for several cycles
        hold_ready = 1'b1;
        send_op(1'b0, 128, 28'h4000000, 3);
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL bp_valid: out_valid=%b, expected 1", bus.out_valid);
        end
        repeat (5) @(negedge clk);
        hold_ready = 1'b0;
        wait_done();

        // reset while aligning: the in-flight operation must vanish
        send_op(1'b0, 130, 28'h0800000, 6);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b result=%h, expected 0 1 00000000",
                     bus.out_valid, bus.in_ready, bus.result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        send_op(1'b1, 127, 28'h6000000, 3); wait_done();

        // randomized operands with random consumer stalls
        bp_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom_range(0, 1));
            e = int'($urandom_range(0, 294)) - 40;
            m = 28'($urandom);
            case ($urandom_range(0, 3))
                0: m = m >> $urandom_range(0, 27);
                1: m = {2'b01, m[25:0]};
                2: m = m & 28'h000000F;
                default: ;
            endcase
            send_op(s, e, m, -1);
            wait_done();
        end
        bp_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_normalize_pack.md
Name: fpu_normalize_pack

Overview:
- Downstream stage of the FPU arithmetic core: takes an unpacked, unnormalized result (sign, widened biased exponent, raw mantissa with carry and guard/round/sticky bits).
- Normalizes it iteratively, rounds to nearest-even, and packs it into an IEEE-754 word.
- Multi-cycle, one operation in flight, valid/ready handshake on both sides.

Parameters:
- bitness, 64, packed word width; one of 16/32/64/128/256.
- EW, derived: 5/8/11/15/19, exponent width for bitness 16/32/64/128/256.
- MW, derived: 11/24/53/113/237, mantissa width including hidden bit, same order.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  stage can accept an operand
- in_sign  input  1  result sign
- in_exp  input  EW+2  signed two's-complement biased exponent
- in_mant  input  MW+4  raw mantissa: [MW+3] carry, [MW+2:3] significand (hidden bit at MW+2), [2] guard, [1] round, [0] sticky
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  bitness  packed IEEE word {sign, exp[EW-1:0], frac[MW-2:0]}

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, result=0, internal registers cleared.
- Reset asserted mid-operation: the operation is discarded and no result is produced.
- States: IDLE, ALIGN, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, register sign/exp/mant and go to ALIGN; in_ready drops the next cycle.
- ALIGN, one action per cycle, checked in this priority order:
  - (a) mant==0: zero result; go to DONE with {sign, 0, 0}.
  - (b) carry bit set: shift right 1, exp+1, OR the shifted-out bit into sticky.
  - (c) exp<1: shift right 1, exp+1, sticky accumulates.
  - (d) hidden bit clear and exp>1: shift left 1, exp-1.
  - (e) otherwise go to ROUND.
- ROUND, one cycle:
  - Round-to-nearest-even: increment the significand when G && (R || S || LSB).
  - If the increment carries out, shift right 1 and exp+1.
  - If exp >= 2^EW-1, result = {sign, all-ones, 0} (infinity).
  - Else if the hidden bit is clear (subnormal, exp==1), the encoded exponent is 0.
  - Else the encoded exponent = exp[EW-1:0].
  - Fraction = significand without the hidden bit.
  - Go to DONE.
- DONE:
  - out_valid=1; result held stable while out_ready=0.
  - On out_ready, out_valid=0, state IDLE, in_ready=1 the following cycle. No back-to-back overlap.
- Latency from accept to out_valid: 3 cycles plus the number of ALIGN shift cycles. Zero operand: 2 cycles.
- Input exp >= 2^EW-1 with nonzero mant also yields infinity. NaN/Inf inputs are out of scope; upstream bypasses them.
- in_valid while in_ready=0 is ignored; the upstream stage holds.

Optional Feature:
- FPU_NORM_FLAGS_EN: adds outputs flag_overflow, flag_underflow, flag_inexact (1 bit each). They are valid with out_valid, reset to 0, and cleared on the out_ready handshake.
  - overflow: infinity produced.
  - underflow: result subnormal or zero-after-rounding from nonzero input, and inexact.
  - inexact: any of G/R/S set at ROUND.
- Without the macro these ports do not exist and no flag logic is generated.

Test Plan (all with bitness=32, raw width 28):
- Normal value: sign=0, exp=127, mant=0x4000000, out_ready=1 -> result 0x3F800000, out_valid 3 cycles after accept.
- Left normalize: exp=130, mant=0x0800000 -> 3 left shifts -> 0x3F800000 at cycle 6.
- Carry normalize: exp=127, mant=0x8000000 -> 0x40000000.
- Rounding ties to even:
  - mant=0x4000004, exp=127 -> 0x3F800000, inexact=1.
  - mant=0x400000C -> 0x3F800002.
- Overflow and zero:
  - sign=1, exp=255, mant=0x4000000 -> 0xFF800000, overflow=1.
  - sign=1, mant=0 -> 0x80000000 after 2 cycles.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> result stable, in_ready=0. Then assert rst_n=0 in ALIGN -> out_valid=0, in_ready=1 immediately, no stale result after release.
